// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM.
// MC_ILLEGAL_TRAP_EN adds the TRAP state for unknown opcodes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC,
    S_R_WB,
    S_BRANCH,
    S_JUMP,
    S_ADDI_EXEC,
    S_ADDI_WB
`ifdef MC_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [2:0] ALU_IDLE  = 3'b000;
  localparam logic [2:0] ALU_RTYPE = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b100;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait timeout counter: counts not-ready cycles while a memory state is
// active and flags expiry at MAX (MAX=0 disables the timeout).
module mc_wait_timer #(
  parameter int unsigned MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ready,
  output logic expire
);

  localparam int unsigned W = (MAX > 0) ? $clog2(MAX + 1) : 1;
  localparam logic [W-1:0] MAX_W = W'(MAX);

  logic [W-1:0] cnt;

  always_comb begin
    expire = (MAX != 0) && active && !ready && (cnt == MAX_W);
  end

  // Saturates at MAX rather than wrapping; expiry clears it anyway.
  always_ff @(posedge clk) begin
    if (rst || !active || ready || expire)
      cnt <= '0;
    else if (cnt != MAX_W)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// Optional MC_ILLEGAL_TRAP_EN: unknown opcodes park in TRAP with illegal_op=1.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       instr_done,
  output logic       mem_err
`ifdef MC_ILLEGAL_TRAP_EN
  , output logic     illegal_op
`endif
);

  state_t state, next_state;
  logic   wait_active;
  logic   expire;
  logic   mem_err_q;

  always_comb begin
    wait_active = !rst && ((state == S_FETCH) || (state == S_MEM_READ) ||
                           (state == S_MEM_WRITE));
  end

  mc_wait_timer #(.MAX(MEM_WAIT_MAX)) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .active (wait_active),
    .ready  (mem_ready),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      mem_err_q <= 1'b0;
    end else begin
      state     <= next_state;
      mem_err_q <= expire;
    end
  end

  always_comb begin
    mem_err = mem_err_q && !rst;
  end

  always_comb begin
    next_state    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    pc_source     = PCSRC_ALU;
    alu_op        = ALU_IDLE;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    instr_done    = 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
    illegal_op    = 1'b0;
`endif
    if (!rst) begin
      unique case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_op    = ALU_ADD;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          if (mem_ready)   next_state = S_DECODE;
          else if (expire) next_state = S_FETCH;
        end
        S_DECODE: begin
          alu_op    = ALU_ADD;
          alu_src_b = SRCB_IMM_SH2;
          case (opcode)
            OP_LW, OP_SW: next_state = S_MEM_ADDR;
            OP_R:         next_state = S_EXEC;
            OP_BEQ:       next_state = S_BRANCH;
            OP_J:         next_state = S_JUMP;
            OP_ADDI:      next_state = S_ADDI_EXEC;
            default: begin
`ifdef MC_ILLEGAL_TRAP_EN
              next_state = S_TRAP;
`else
              instr_done = 1'b1;
              next_state = S_FETCH;
`endif
            end
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_IMM;
          alu_op     = ALU_ADD;
          next_state = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready)   next_state = S_MEM_WB;
          else if (expire) next_state = S_FETCH;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        S_MEM_WRITE: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
          if (mem_ready || expire) next_state = S_FETCH;
        end
        S_EXEC: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_RT;
          alu_op     = ALU_RTYPE;
          next_state = S_R_WB;
        end
        S_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_src_b     = SRCB_RT;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          instr_done    = 1'b1;
          next_state    = S_FETCH;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_source  = PCSRC_JUMP;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
        S_ADDI_EXEC: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRCB_IMM;
          alu_op     = ALU_ADD;
          next_state = S_ADDI_WB;
        end
        S_ADDI_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          next_state = S_FETCH;
        end
`ifdef MC_ILLEGAL_TRAP_EN
        S_TRAP: begin
          illegal_op = 1'b1;
        end
`endif
        default: next_state = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl (MEM_WAIT_MAX=3); honours MC_ILLEGAL_TRAP_EN.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write;
  logic [1:0] pc_source, alu_src_b;
  logic [2:0] alu_op;
  logic       alu_src_a, reg_write, reg_dst, instr_done, mem_err;
  logic       ill_obs;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       illegal_op;
  assign ill_obs = illegal_op;
`else
  assign ill_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_WAIT_MAX(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .ir_write(ir_write), .pc_source(pc_source), .alu_op(alu_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .reg_dst(reg_dst), .instr_done(instr_done), .mem_err(mem_err)
`ifdef MC_ILLEGAL_TRAP_EN
    , .illegal_op(illegal_op)
`endif
  );

  // {illegal_op, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
  //  ir_write, pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, instr_done, mem_err}
  logic [19:0] obs;
  assign obs = {ill_obs, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
                ir_write, pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst,
                instr_done, mem_err};

  typedef struct packed {
    logic        rs;
    logic        rdy;
    logic [19:0] e;
  } stim_t;

  logic [19:0] exp_q[$];
  int unsigned checks = 0;
  int unsigned failures = 0;

  function automatic logic [19:0] mk(input logic ill, pcw, pcwc, iord, mr, mw, m2r, irw,
                                     input logic [1:0] pcs, input logic [2:0] aop,
                                     input logic asa, input logic [1:0] asb,
                                     input logic rw, rd, done, err);
    return {ill, pcw, pcwc, iord, mr, mw, m2r, irw, pcs, aop, asa, asb, rw, rd, done, err};
  endfunction

  function automatic logic [19:0] e_zero();
    return '0;
  endfunction
  function automatic logic [19:0] e_fetch(input logic rdy, input logic err);
    return mk(0, rdy, 0, 0, 1, 0, 0, rdy, 2'b00, 3'b010, 0, 2'b01, 0, 0, 0, err);
  endfunction
  function automatic logic [19:0] e_decode(input logic done);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 0, 2'b11, 0, 0, done, 0);
  endfunction
  function automatic logic [19:0] e_memaddr();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 1, 2'b10, 0, 0, 0, 0);
  endfunction
  function automatic logic [19:0] e_mread();
    return mk(0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 0, 0, 0, 0);
  endfunction
  function automatic logic [19:0] e_mwb();
    return mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 0, 2'b00, 1, 0, 1, 0);
  endfunction
  function automatic logic [19:0] e_mwrite(input logic done);
    return mk(0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 3'b000, 0, 2'b00, 0, 0, done, 0);
  endfunction
  function automatic logic [19:0] e_exec();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b001, 1, 2'b00, 0, 0, 0, 0);
  endfunction
  function automatic logic [19:0] e_rwb();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 1, 1, 1, 0);
  endfunction
  function automatic logic [19:0] e_branch();
    return mk(0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 3'b100, 1, 2'b00, 0, 0, 1, 0);
  endfunction
  function automatic logic [19:0] e_jump();
    return mk(0, 1, 0, 0, 0, 0, 0, 0, 2'b10, 3'b000, 0, 2'b00, 0, 0, 1, 0);
  endfunction
  function automatic logic [19:0] e_addi_exec();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b010, 1, 2'b10, 0, 0, 0, 0);
  endfunction
  function automatic logic [19:0] e_addi_wb();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 1, 0, 1, 0);
  endfunction
  function automatic logic [19:0] e_trap();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 2'b00, 0, 0, 0, 0);
  endfunction

  // Drives one cycle's inputs away from the rising edge and queues the expectation.
  task automatic drive(input stim_t s);
    @(negedge clk);
    rst = s.rs;
    mem_ready = s.rdy;
    exp_q.push_back(s.e);
    #1;
  endtask

  task automatic test_reset();
    stim_t seq[$];
    logic [19:0] e;
    opcode = 6'b100011;
    seq.push_back('{1'b1, 1'b1, e_zero()});
    seq.push_back('{1'b1, 1'b0, e_zero()});
    seq.push_back('{1'b0, 1'b0, e_fetch(0, 0)});
    for (int unsigned i = 0; i < seq.size(); i++) begin
      drive(seq[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset cyc%0d got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_rtype();
    stim_t seq[$];
    logic [19:0] e;
    opcode = 6'b000000;
    seq.push_back('{1'b0, 1'b1, e_fetch(1, 0)});
    seq.push_back('{1'b0, 1'b1, e_decode(0)});
    seq.push_back('{1'b0, 1'b1, e_exec()});
    seq.push_back('{1'b0, 1'b1, e_rwb()});
    for (int unsigned i = 0; i < seq.size(); i++) begin
      drive(seq[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL rtype cyc%0d got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_lw_stall();
    stim_t seq[$];
    logic [19:0] e;
    opcode = 6'b100011;
    seq.push_back('{1'b0, 1'b1, e_fetch(1, 0)});
    seq.push_back('{1'b0, 1'b1, e_decode(0)});
    seq.push_back('{1'b0, 1'b1, e_memaddr()});
    seq.push_back('{1'b0, 1'b0, e_mread()});
    seq.push_back('{1'b0, 1'b0, e_mread()});
    seq.push_back('{1'b0, 1'b0, e_mread()});
    seq.push_back('{1'b0, 1'b1, e_mread()});
    seq.push_back('{1'b0, 1'b1, e_mwb()});
    for (int unsigned i = 0; i < seq.size(); i++) begin
      drive(seq[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL lw_stall cyc%0d got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_branch_jump();
    stim_t seq[$];
    logic [19:0] e;
    opcode = 6'b000100;
    seq.push_back('{1'b0, 1'b1, e_fetch(1, 0)});
    seq.push_back('{1'b0, 1'b1, e_decode(0)});
    seq.push_back('{1'b0, 1'b1, e_branch()});
    for (int unsigned i = 0; i < seq.size(); i++) begin
      drive(seq[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL beq cyc%0d got=%h exp=%h", i, obs, e);
      end
    end
    seq.delete();
    opcode = 6'b000010;
    seq.push_back('{1'b0, 1'b1, e_fetch(1, 0)});
    seq.push_back('{1'b0, 1'b0, e_decode(0)});
    seq.push_back('{1'b0, 1'b0, e_jump()});
    for (int unsigned i = 0; i < seq.size(); i++) begin
      drive(seq[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL jump cyc%0d got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t seq[$];
    logic [19:0] e;
    opcode = 6'b001000;
    seq.push_back('{1'b0, 1'b1, e_fetch(1, 0)});
    seq.push_back('{1'b0, 1'b1, e_decode(0)});
    seq.push_back('{1'b0, 1'b1, e_addi_exec()});
    seq.push_back('{1'b0, 1'b1, e_addi_wb()});
    seq.push_back('{1'b0, 1'b0, e_fetch(0, 0)});
    seq.push_back('{1'b0, 1'b1, e_fetch(1, 0)});
    for (int unsigned i = 0; i < seq.size(); i++) begin
      drive(seq[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL addi cyc%0d got=%h exp=%h", i, obs, e);
      end
    end
    seq.delete();
    opcode = 6'b000100;
    seq.push_back('{1'b0, 1'b1, e_decode(0)});
    seq.push_back('{1'b0, 1'b1, e_branch()});
    for (int unsigned i = 0; i < seq.size(); i++) begin
      drive(seq[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL b2b_beq cyc%0d got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_sw_timeout();
    stim_t seq[$];
    logic [19:0] e;
    opcode = 6'b101011;
    seq.push_back('{1'b0, 1'b1, e_fetch(1, 0)});
    seq.push_back('{1'b0, 1'b1, e_decode(0)});
    seq.push_back('{1'b0, 1'b1, e_memaddr()});
    for (int unsigned k = 0; k < 4; k++) seq.push_back('{1'b0, 1'b0, e_mwrite(0)});
    seq.push_back('{1'b0, 1'b0, e_fetch(0, 1)});
    seq.push_back('{1'b0, 1'b1, e_fetch(1, 0)});
    seq.push_back('{1'b0, 1'b1, e_decode(0)});
    seq.push_back('{1'b0, 1'b1, e_memaddr()});
    for (int unsigned k = 0; k < 3; k++) seq.push_back('{1'b0, 1'b0, e_mwrite(0)});
    seq.push_back('{1'b0, 1'b1, e_mwrite(1)});
    seq.push_back('{1'b0, 1'b0, e_fetch(0, 0)});
    for (int unsigned i = 0; i < seq.size(); i++) begin
      drive(seq[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL sw_timeout cyc%0d got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_illegal();
    stim_t seq[$];
    logic [19:0] e;
    opcode = 6'b111111;
    seq.push_back('{1'b0, 1'b1, e_fetch(1, 0)});
`ifdef MC_ILLEGAL_TRAP_EN
    seq.push_back('{1'b0, 1'b1, e_decode(0)});
    seq.push_back('{1'b0, 1'b1, e_trap()});
    seq.push_back('{1'b0, 1'b0, e_trap()});
    seq.push_back('{1'b0, 1'b1, e_trap()});
`else
    seq.push_back('{1'b0, 1'b1, e_decode(1)});
    seq.push_back('{1'b0, 1'b0, e_fetch(0, 0)});
`endif
    seq.push_back('{1'b1, 1'b1, e_zero()});
    seq.push_back('{1'b0, 1'b0, e_fetch(0, 0)});
    for (int unsigned i = 0; i < seq.size(); i++) begin
      drive(seq[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL illegal cyc%0d got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  // Reset lands on the timeout cycle, so the pending mem_err must be dropped.
  task automatic test_reset_mid();
    stim_t seq[$];
    logic [19:0] e;
    opcode = 6'b100011;
    seq.push_back('{1'b0, 1'b1, e_fetch(1, 0)});
    seq.push_back('{1'b0, 1'b1, e_decode(0)});
    seq.push_back('{1'b0, 1'b1, e_memaddr()});
    for (int unsigned k = 0; k < 3; k++) seq.push_back('{1'b0, 1'b0, e_mread()});
    seq.push_back('{1'b1, 1'b0, e_zero()});
    seq.push_back('{1'b0, 1'b0, e_fetch(0, 0)});
    seq.push_back('{1'b0, 1'b1, e_fetch(1, 0)});
    for (int unsigned i = 0; i < seq.size(); i++) begin
      drive(seq[i]);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_mid cyc%0d got=%h exp=%h", i, obs, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_branch_jump();
    test_back_to_back();
    test_sw_timeout();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences fetch/decode/execute/memory/writeback steps and drives the ALU control unit's 3-bit ALUOp.
- Drives all datapath mux selects and write enables.
- Handles variable-latency memory via a ready handshake with a wait timeout.

Parameters:
- MEM_WAIT_MAX, 15: maximum consecutive not-ready cycles in a memory state before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  instruction[31:26] from the instruction register; stable outside FETCH
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load gated by ALU zero (beq)
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_to_reg  out  1  register write data select: 1=MDR, 0=ALUOut
- ir_write  out  1  instruction register load
- pc_source  out  2  00=ALU, 01=ALUOut, 10=jump target
- alu_op  out  3  001=R-type (func decoded), 010=add, 100=sub, 000=idle
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- reg_write  out  1  register file write
- reg_dst  out  1  destination register select: 1=rd, 0=rt
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- mem_err  out  1  registered one-cycle pulse after a memory timeout

Behaviour:
- State register updates on rising clk; rst is synchronous and active-high.
- While rst=1, all outputs are forced 0. The cycle after rst deasserts, state is FETCH, wait counter is 0 and mem_err is 0.
- Outputs decode from state, plus mem_ready where noted; any output not listed for a state is 0.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=010, pc_source=00.
  - ir_write = pc_write = mem_ready.
  - mem_ready -> DECODE; otherwise stay.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=010 (precomputes branch target).
  - Next state by opcode: lw/sw -> MEM_ADDR; R -> EXEC; beq -> BRANCH; j -> JUMP; addi -> ADDI_EXEC.
  - Unknown opcode -> FETCH with instr_done=1 (treated as NOP).
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=010. lw -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1. mem_ready -> MEM_WB; otherwise stay.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 -> FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1. On mem_ready: instr_done=1 -> FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=001 -> R_WB.
- R_WB: reg_write=1, reg_dst=1, instr_done=1 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=100, pc_write_cond=1, pc_source=01, instr_done=1 -> FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1 -> FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=010 -> ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 -> FETCH.
- Instruction latency with zero memory wait:
  - 3 cycles: beq, j.
  - 4 cycles: R-type, addi, sw.
  - 5 cycles: lw.
- Wait timeout (FETCH, MEM_READ, MEM_WRITE):
  - Counter increments on each cycle with mem_ready=0 and clears on leaving the state or on mem_ready=1.
  - When the counter equals MEM_WAIT_MAX and mem_ready=0: next state is FETCH, counter clears, mem_err=1 the following cycle. No instr_done and no register or PC write occur.
  - If mem_ready=1 in the terminal count cycle, ready wins and the access completes normally.
  - Counter width is clog2(MEM_WAIT_MAX+1); it never wraps.
- Reset mid-instruction abandons the instruction; any pending mem_err pulse is cleared.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output port illegal_op (1 bit).
  - An unknown opcode in DECODE -> TRAP state: illegal_op=1, all other outputs 0.
  - TRAP holds until rst; no instr_done is issued.
- Undefined: no port and no TRAP state; an unknown opcode behaves as a NOP as described above.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - ALUOp constants (IDLE/RTYPE/ADD/SUB);
  - alu_src_b and pc_source encodings.
- One sub-module, mc_wait_timer: inputs clk, rst, active, ready; output expire. Holds the timeout counter.

Test Plan:
- rst=1 for 2 cycles, then release -> all outputs 0 during reset. First cycle after: mem_read=1, alu_op=010, alu_src_b=01.
- R-type (opcode 000000), mem_ready always 1 -> FETCH, DECODE, EXEC (alu_op=001), R_WB (reg_write=1, reg_dst=1). instr_done on cycle 4.
- lw (100011), mem_ready low 3 cycles in MEM_READ -> stalls exactly 3 extra cycles, then MEM_WB with mem_to_reg=1. Total 8 cycles.
- beq (000100) -> BRANCH cycle shows alu_op=100, pc_write_cond=1, pc_source=01. j (000010) -> pc_write=1, pc_source=10.
- MEM_WAIT_MAX=3, sw with mem_ready held 0 -> after 4 wait cycles returns to FETCH with mem_err=1 for 1 cycle; mem_write=0 afterwards. Repeat with mem_ready=1 on the 4th wait cycle -> no mem_err, instr_done=1.
- Opcode 111111:
  - without MC_ILLEGAL_TRAP_EN -> FETCH after DECODE, instr_done=1;
  - with it -> illegal_op=1 held until rst.
